// File: rtl/ram_dp_hs.sv
// Simple dual-port RAM with write/read handshakes, a 1- or 2-stage registered read
// pipeline with ReadValid, and a zero-fill sweep after reset or on a clear request.
module ram_dp_hs #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int READ_LATENCY  = 1,
  parameter int WRITE_FIRST   = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] WriteAddr,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic                  WriteReady,
  input  logic                  read,
  input  logic [ADDR_WIDTH-1:0] ReadAddr,
  output logic                  ReadReady,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  ReadValid,
  output logic                  Busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   sweepAddr_q, sweepAddr_d;
  logic                    ready_q, ready_d;
  logic                    sweepWe;
  logic                    writeAcc, readAcc, bypass;
  logic                    memWe;
  logic [ADDR_WIDTH-1:0]   memAddr;
  logic [DATA_WIDTH-1:0]   memData;
  logic [DATA_WIDTH-1:0]   memArray_q [DEPTH];
  logic [DATA_WIDTH-1:0]   rdData1_q;
  logic                    rdValid1_q;

  assign writeAcc = write & ready_q;
  assign readAcc  = read & ready_q;
  assign bypass   = (WRITE_FIRST != 0) && writeAcc && (WriteAddr == ReadAddr);

  assign WriteReady = ready_q;
  assign ReadReady  = ready_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if (INIT_ON_RESET != 0) begin
        state_q <= INIT;
      end else begin
        state_q <= RUN;
      end
      sweepAddr_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweepAddr_q <= sweepAddr_d;
      ready_q     <= ready_d;
    end
  end

  // The sweep ends on a terminal compare, so the address never wraps back into the array.
  always_comb begin
    state_d     = state_q;
    sweepAddr_d = sweepAddr_q;
    case (state_q)
      INIT: begin
        if (clear) begin
          sweepAddr_d = '0;
        end else if (sweepAddr_q == LastAddr) begin
          state_d     = RUN;
          sweepAddr_d = '0;
        end else begin
          sweepAddr_d = sweepAddr_q + ADDR_WIDTH'(1);
        end
      end
      RUN: begin
        if (clear) begin
          state_d     = INIT;
          sweepAddr_d = '0;
        end
      end
      default: begin
        state_d     = INIT;
        sweepAddr_d = '0;
      end
    endcase
  end

  always_comb begin
    sweepWe = (state_q == INIT);
    Busy    = (state_q == INIT);
    ready_d = (state_d == RUN);
  end

  // Handshake writes and sweep writes are mutually exclusive because readies are low in INIT.
  always_comb begin
    memWe   = writeAcc | sweepWe;
    memAddr = sweepWe ? sweepAddr_q : WriteAddr;
    memData = sweepWe ? '0 : WriteData;
  end

  always_ff @(posedge clock) begin
    if (memWe) begin
      memArray_q[memAddr] <= memData;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdData1_q  <= '0;
      rdValid1_q <= 1'b0;
    end else begin
      rdValid1_q <= readAcc;
      if (readAcc) begin
        rdData1_q <= bypass ? WriteData : memArray_q[ReadAddr];
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : gLat2
      logic [DATA_WIDTH-1:0] rdData2_q;
      logic                  rdValid2_q;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          rdData2_q  <= '0;
          rdValid2_q <= 1'b0;
        end else begin
          rdValid2_q <= rdValid1_q;
          if (rdValid1_q) begin
            rdData2_q <= rdData1_q;
          end
        end
      end

      assign ReadData  = rdData2_q;
      assign ReadValid = rdValid2_q;
    end else begin : gLat1
      assign ReadData  = rdData1_q;
      assign ReadValid = rdValid1_q;
    end
  endgenerate

endmodule

// File: doc/ram_dp_hs.md
# ram_dp_hs

Parametrised simple dual-port RAM with independent write and read handshake ports, a registered read pipeline with explicit data-valid, and a hardware zero-fill sweep on reset or on request. It generalises the team's 16×8 RAM: width, depth and read latency are parameters, and it adds ReadValid, read/write collision policy and a clear mode. It sits between producer/consumer logic and on-chip memory, on the single system clock.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH
- READ_LATENCY, 1, read pipeline depth; legal values 1 or 2
- WRITE_FIRST, 1, same-address collision policy: 1 returns new data, 0 returns old data
- INIT_ON_RESET, 1, 1 runs the zero-fill sweep after reset; 0 goes straight to RUN

- clock  in  1  system clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous request to zero-fill the whole array
- write  in  1  write request; accepted when write & WriteReady at an edge
- WriteAddr  in  ADDR_WIDTH  write address
- WriteData  in  DATA_WIDTH  write data
- WriteReady  out  1  write port can accept
- read  in  1  read request; accepted when read & ReadReady at an edge
- ReadAddr  in  ADDR_WIDTH  read address
- ReadReady  out  1  read port can accept
- ReadData  out  DATA_WIDTH  read result; holds last value between reads
- ReadValid  out  1  one-cycle pulse marking new ReadData
- Busy  out  1  zero-fill sweep in progress

## Operation
- Reset (async): WriteReady=0, ReadReady=0, ReadValid=0, ReadData=0, Busy=INIT_ON_RESET, sweep counter=0, read pipeline flushed. State = INIT if INIT_ON_RESET, else RUN. Array contents are not reset.
- States: INIT, RUN.
- INIT: writes 0 to sweep address 0, 1, …, DEPTH-1, one per edge. On the edge that writes DEPTH-1: go to RUN, Busy→0, WriteReady→1, ReadReady→1. The counter is ADDR_WIDTH+1 bits wide or uses a terminal compare; it never wraps back into the array. write and read are ignored in INIT.
- RUN: WriteReady=ReadReady=1 continuously. The block is fully pipelined: one write and one read can be accepted on every edge.
- clear sampled high in RUN: go to INIT and set the counter to 0. Busy→1 and both readies→0 on that same edge. A write or read presented on that edge is still accepted.
- clear sampled high in INIT: restart the sweep at address 0.
- Reads accepted before a clear complete normally, returning pre-clear data.
- Collision: a write and a read accepted on the same edge at the same address return WriteData if WRITE_FIRST=1, else the prior contents. Different addresses are independent.
- Requests issued while the corresponding ready is 0 are dropped silently and do not stall.

## Timing
- Write accepted at edge N: the location is updated at edge N. A read accepted at edge N+1 or later returns the new data.
- Read accepted at edge N:
  - READ_LATENCY=1: ReadData and ReadValid update at edge N, valid during cycle N→N+1.
  - READ_LATENCY=2: they update at edge N+1.
- ReadValid is high for exactly one cycle per accepted read. Back-to-back reads give a continuous ReadValid.
- Readies rise exactly DEPTH edges after the first edge at which reset is low, when INIT_ON_RESET=1. With INIT_ON_RESET=0 they rise on that first edge.
- Reset mid-sweep or mid-read: the async clear wins immediately. In-flight ReadValid pulses are lost, and the sweep restarts from 0 after release.

## Test plan
- Reset release, defaults (8/4/1/1/1): readies=0 and Busy=1 for 16 edges, then readies=1 and Busy=0. Reads of addresses 0–15 all return 0x00 with one ReadValid each.
- Sequential write of addr k = k*17 (0x00–0xFF), then back-to-back reads of 0–15 → ReadData k*17 one edge after each accept, continuous ReadValid for 16 cycles. Repeat with READ_LATENCY=2 → each result one edge later.
- Same-edge write 0xA5 and read to addr 3, which holds 0x11: WRITE_FIRST=1 → 0xA5; WRITE_FIRST=0 → 0x11, and a following read → 0xA5.
- After filling the array, pulse clear while a read of addr 5 (0x55) is in flight → that read returns 0x55. Readies drop on the clear edge for 16 edges, then all reads return 0x00. Writes attempted during INIT do not land.
- Assert reset at sweep address 7 and while a read is pending → all outputs reset at once with no ReadValid, and the full 16-edge sweep reruns after release.
- ADDR_WIDTH=6, DATA_WIDTH=16: write 0xBEEF to addr 63 and 0x1234 to addr 0 → readback exact, no aliasing. The sweep lasts 64 edges.
